// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback sequencer for an 8-bit instruction stream.
// Define CPU_SEQ_TRAP_EN to trap reserved opcodes (110/111) into HALT; otherwise they run as NOPs.
module cpu_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [2:0]       alu_op,
    output logic [2:0]       rd_sel,
    output logic [2:0]       rs_sel,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [7:0]       ir_q, ir_d;
    logic             reserved;

    assign reserved = (ir_q[7:6] == 2'b11);

`ifdef CPU_SEQ_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            retired_q <= '0;
            ir_q      <= '0;
`ifdef CPU_SEQ_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            ir_q      <= ir_d;
`ifdef CPU_SEQ_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ir_d      = ir_q;
`ifdef CPU_SEQ_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
`ifdef CPU_SEQ_TRAP_EN
                if (reserved) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
`else
                state_d = EXEC;
`endif
            end
            EXEC: state_d = WB;
            WB: begin
                pc_d      = pc_q + 1'b1;
                retired_d = retired_q + 1'b1;
                state_d   = stop ? IDLE : FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Decode fields come straight from ir, which only changes on leaving FETCH,
    // so they hold their value everywhere else without extra registers.
    assign alu_op    = ir_q[7:5];
    assign rd_sel    = {1'b0, ir_q[4:3]};
    assign rs_sel    = ir_q[2:0];
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    // A reset landing in WB discards the write along with the pc/retired update.
    assign reg_we    = (state_q == WB) && !reserved && !rst;
    assign busy      = (state_q != IDLE) && (state_q != HALT);
    assign halted    = (state_q == HALT);
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer; expectations follow the same CPU_SEQ_TRAP_EN setting as the DUT.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop, imem_ack;
    logic        imem_req, reg_we, busy, halted, illegal;
    logic [7:0]  imem_addr, imem_data, pc;
    logic [2:0]  alu_op, rd_sel, rs_sel;
    logic [15:0] retired;
    logic        ack_en;
    logic [7:0]  mem [0:255];
    int          we_count = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    assign imem_ack  = ack_en;
    assign imem_data = mem[imem_addr];

    always @(posedge clk) if (reg_we) we_count <= we_count + 1;

    cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_op(alu_op), .rd_sel(rd_sel), .rs_sel(rs_sel), .reg_we(reg_we),
        .busy(busy), .halted(halted), .illegal(illegal), .pc(pc), .retired(retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0; stop = 1'b0; ack_en = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b0 || reg_we !== 1'b0) $display("FAIL rst_req_we: got %b%b want 00", imem_req, reg_we); else pass_cnt++;
        total_cnt++; if (pc !== 8'd0 || retired !== 16'd0) $display("FAIL rst_pc_ret: got %0d/%0d want 0/0", pc, retired); else pass_cnt++;
        total_cnt++; if ({alu_op, rd_sel, rs_sel} !== 9'd0) $display("FAIL rst_fields: got %h want 0", {alu_op, rd_sel, rs_sel}); else pass_cnt++;
        rst = 1'b0;
        tick();
        $display("reset: pc=%0d retired=%0d busy=%b", pc, retired, busy);
    endtask

    task automatic test_single_add();
        int we0;
        mem[0] = 8'h0B;
        we0 = we_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1) $display("FAIL add_fetch: got req=%b addr=%0d busy=%b want 1/0/1", imem_req, imem_addr, busy); else pass_cnt++;
        tick();
        total_cnt++; if (reg_we !== 1'b0 || imem_req !== 1'b0) $display("FAIL add_decode: got we=%b req=%b want 0/0", reg_we, imem_req); else pass_cnt++;
        tick();
        total_cnt++; if (reg_we !== 1'b0) $display("FAIL add_exec_we: got %b want 0", reg_we); else pass_cnt++;
        tick();
        total_cnt++; if (reg_we !== 1'b1) $display("FAIL add_wb_we: got %b want 1", reg_we); else pass_cnt++;
        total_cnt++; if (alu_op !== 3'd0 || rd_sel !== 3'd1 || rs_sel !== 3'd3) $display("FAIL add_fields: got %0d/%0d/%0d want 0/1/3", alu_op, rd_sel, rs_sel); else pass_cnt++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total_cnt++; if (pc !== 8'd1 || retired !== 16'd1) $display("FAIL add_pc_ret: got %0d/%0d want 1/1", pc, retired); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL add_idle: got busy=%b req=%b want 0/0", busy, imem_req); else pass_cnt++;
        total_cnt++; if (rd_sel !== 3'd1 || rs_sel !== 3'd3) $display("FAIL add_hold: got %0d/%0d want 1/3", rd_sel, rs_sel); else pass_cnt++;
        total_cnt++; if (we_count - we0 !== 1) $display("FAIL add_we_pulses: got %0d want 1", we_count - we0); else pass_cnt++;
        $display("single_add: pc=%0d retired=%0d", pc, retired);
    endtask

    task automatic test_wait_states();
        int we0;
        mem[1] = 8'h2A;
        we0 = we_count;
        ack_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 8'd1) $display("FAIL wait_fetch%0d: got req=%b addr=%0d want 1/1", i, imem_req, imem_addr); else pass_cnt++;
            if (i == 3) ack_en = 1'b1;
            tick();
        end
        total_cnt++; if (alu_op !== 3'd1 || rd_sel !== 3'd1 || rs_sel !== 3'd2 || imem_req !== 1'b0) $display("FAIL wait_decode: got %0d/%0d/%0d req=%b want 1/1/2 req=0", alu_op, rd_sel, rs_sel, imem_req); else pass_cnt++;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total_cnt++; if (we_count - we0 !== 1) $display("FAIL wait_we_pulses: got %0d want 1", we_count - we0); else pass_cnt++;
        total_cnt++; if (pc !== 8'd2 || retired !== 16'd2 || busy !== 1'b0) $display("FAIL wait_end: got pc=%0d ret=%0d busy=%b want 2/2/0", pc, retired, busy); else pass_cnt++;
        $display("wait_states: pc=%0d retired=%0d", pc, retired);
    endtask

    task automatic test_stop_wrap();
        int n;
        int cyc;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h5B;
        n = 0;
        cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (busy === 1'b1 && cyc < 3000) begin
            cyc++;
            if (reg_we === 1'b1) begin
                n++;
                if (n == 256) stop = 1'b1;
            end
            tick();
        end
        stop = 1'b0;
        total_cnt++; if (n !== 256) $display("FAIL wrap_count: got %0d want 256", n); else pass_cnt++;
        total_cnt++; if (cyc !== 1024) $display("FAIL wrap_cycles: got %0d want 1024", cyc); else pass_cnt++;
        total_cnt++; if (pc !== 8'd0 || retired !== 16'd256) $display("FAIL wrap_pc_ret: got %0d/%0d want 0/256", pc, retired); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL wrap_idle: got busy=%b req=%b want 0/0", busy, imem_req); else pass_cnt++;
        total_cnt++; if (alu_op !== 3'd2 || rd_sel !== 3'd3 || rs_sel !== 3'd3) $display("FAIL wrap_fields: got %0d/%0d/%0d want 2/3/3", alu_op, rd_sel, rs_sel); else pass_cnt++;
        $display("stop_wrap: instr=%0d cycles=%0d pc=%0d retired=%0d", n, cyc, pc, retired);
    endtask

    task automatic test_reserved();
        int we0;
        mem[0] = 8'hC0;
        mem[1] = 8'h0B;
        we0 = we_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total_cnt++; if (alu_op !== 3'd6 || reg_we !== 1'b0) $display("FAIL rsv_decode: got op=%0d we=%b want 6/0", alu_op, reg_we); else pass_cnt++;
        tick();
`ifdef CPU_SEQ_TRAP_EN
        total_cnt++; if (halted !== 1'b1 || illegal !== 1'b1 || busy !== 1'b0) $display("FAIL rsv_halt: got h=%b i=%b busy=%b want 1/1/0", halted, illegal, busy); else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total_cnt++; if (halted !== 1'b1 || imem_req !== 1'b0 || reg_we !== 1'b0) $display("FAIL rsv_stay: got h=%b req=%b we=%b want 1/0/0", halted, imem_req, reg_we); else pass_cnt++;
        total_cnt++; if (pc !== 8'd0 || retired !== 16'd256) $display("FAIL rsv_pc_ret: got %0d/%0d want 0/256", pc, retired); else pass_cnt++;
        total_cnt++; if (we_count - we0 !== 0) $display("FAIL rsv_we_pulses: got %0d want 0", we_count - we0); else pass_cnt++;
`else
        tick();
        total_cnt++; if (reg_we !== 1'b0 || busy !== 1'b1) $display("FAIL rsv_wb: got we=%b busy=%b want 0/1", reg_we, busy); else pass_cnt++;
        tick();
        total_cnt++; if (imem_req !== 1'b1 || pc !== 8'd1 || retired !== 16'd257 || illegal !== 1'b0) $display("FAIL rsv_next: got req=%b pc=%0d ret=%0d ill=%b want 1/1/257/0", imem_req, pc, retired, illegal); else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++; if (reg_we !== 1'b1 || rd_sel !== 3'd1) $display("FAIL rsv_follow_wb: got we=%b rd=%0d want 1/1", reg_we, rd_sel); else pass_cnt++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total_cnt++; if (pc !== 8'd2 || halted !== 1'b0 || we_count - we0 !== 1) $display("FAIL rsv_end: got pc=%0d h=%b we=%0d want 2/0/1", pc, halted, we_count - we0); else pass_cnt++;
`endif
        $display("reserved: pc=%0d retired=%0d halted=%b illegal=%b", pc, retired, halted, illegal);
    endtask

    task automatic test_reset_mid();
        int we0;
        do_reset();
        mem[0] = 8'h3F;
        we0 = we_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b1 || reg_we !== 1'b0) $display("FAIL mid_exec: got busy=%b we=%b want 1/0", busy, reg_we); else pass_cnt++;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        total_cnt++; if (busy !== 1'b0 || pc !== 8'd0 || retired !== 16'd0) $display("FAIL mid_idle: got busy=%b pc=%0d ret=%0d want 0/0/0", busy, pc, retired); else pass_cnt++;
        total_cnt++; if ({alu_op, rd_sel, rs_sel} !== 9'd0) $display("FAIL mid_fields: got %h want 0", {alu_op, rd_sel, rs_sel}); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL mid_start_ignored: got busy=%b req=%b want 0/0", busy, imem_req); else pass_cnt++;
        total_cnt++; if (we_count - we0 !== 0) $display("FAIL mid_we_pulses: got %0d want 0", we_count - we0); else pass_cnt++;
        $display("reset_mid: pc=%0d retired=%0d busy=%b", pc, retired, busy);
    endtask

    task automatic test_reset_wb();
        int we0;
        mem[0] = 8'h0B;
        we0 = we_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        total_cnt++; if (reg_we !== 1'b0) $display("FAIL wbrst_we: got %b want 0", reg_we); else pass_cnt++;
        tick();
        rst = 1'b0;
        total_cnt++; if (pc !== 8'd0 || retired !== 16'd0 || busy !== 1'b0) $display("FAIL wbrst_state: got pc=%0d ret=%0d busy=%b want 0/0/0", pc, retired, busy); else pass_cnt++;
        total_cnt++; if (we_count - we0 !== 0) $display("FAIL wbrst_we_pulses: got %0d want 0", we_count - we0); else pass_cnt++;
        $display("reset_wb: pc=%0d retired=%0d", pc, retired);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ack_en = 1'b1;
        test_reset();
        test_single_add();
        test_wait_states();
        test_stop_wrap();
        test_reserved();
        test_reset_mid();
        test_reset_wb();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program counter and instruction address width.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle pulse; begins execution from the current pc when the sequencer is in IDLE.
REQ-006 stop  input  1  level request to return to IDLE after the current instruction completes.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  PC_W  fetch address; equals pc.
REQ-009 imem_ack  input  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-010 imem_data  input  8  instruction byte.
REQ-011 alu_op  output  3  ALU operation, ir[7:5].
REQ-012 rd_sel  output  3  destination register, {1'b0, ir[4:3]}.
REQ-013 rs_sel  output  3  source register, ir[2:0].
REQ-014 reg_we  output  1  register-file write enable.
REQ-015 busy  output  1  high in any state other than IDLE and HALT.
REQ-016 halted  output  1  high in HALT.
REQ-017 illegal  output  1  sticky flag: a reserved opcode has trapped.
REQ-018 pc  output  PC_W  program counter.
REQ-019 retired  output  CNT_W  count of completed instructions.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-021 IDLE SHALL move to FETCH on start=1; start SHALL be ignored in every other state.
REQ-022 In FETCH, imem_req SHALL be 1.
- If imem_ack=0, the FSM holds in FETCH with imem_addr stable.
- If imem_ack=1, the FSM latches imem_data into ir and moves to DECODE.
REQ-023 imem_ack SHALL be ignored outside FETCH.
REQ-024 DECODE, EXEC and WB SHALL each last exactly one cycle.
- alu_op, rd_sel and rs_sel are driven from ir and held stable from DECODE through WB.
- These outputs keep their last value in IDLE, FETCH and HALT.
REQ-025 reg_we SHALL be 1 only in WB, and only for opcodes 000-101.
REQ-026 On leaving WB, the sequencer SHALL update state as follows:
- pc increments by 1, wrapping from 2^PC_W-1 to 0.
- retired increments by 1, wrapping from 2^CNT_W-1 to 0.
- The next state is IDLE if stop=1 in the WB cycle, otherwise FETCH.
REQ-027 The minimum instruction period SHALL be 4 cycles (FETCH with immediate ack, DECODE, EXEC, WB).
REQ-028 stop SHALL be sampled only in WB and SHALL never abort an instruction in flight.
REQ-029 HALT SHALL be left only through rst.
- busy=0, halted=1, imem_req=0 and reg_we=0 in HALT.
- pc points at the trapping instruction.

Reset
REQ-030 On rst=1 at a clock edge, the sequencer SHALL reset as follows:
- The state returns to IDLE.
- pc=0, retired=0 and ir=0.
- alu_op, rd_sel and rs_sel are 0.
- reg_we, imem_req, busy, halted and illegal are 0.
REQ-031 rst SHALL take priority over start, stop and imem_ack in the same cycle.
REQ-032 Reset during FETCH or WB SHALL discard the instruction: no write and no pc or retired update.

Configuration
REQ-033 The macro CPU_SEQ_TRAP_EN SHALL select how reserved opcodes 110 and 111 are handled.
REQ-034 With CPU_SEQ_TRAP_EN defined, a reserved opcode detected in DECODE SHALL go to HALT on the next edge.
- illegal=1 and reg_we stays 0.
- pc and retired are not updated.
REQ-035 Without CPU_SEQ_TRAP_EN, a reserved opcode SHALL execute as a NOP.
- It passes through EXEC and WB with reg_we=0.
- pc and retired increment.
- The illegal output is tied to 0 and HALT is unreachable.

Verification
REQ-036 Single ADD: reset, start; imem_data=8'h0B with ack in the first FETCH cycle -> 4th cycle WB with reg_we=1, alu_op=0, rd_sel=1, rs_sel=3; then pc=1, retired=1.
REQ-037 Wait states: imem_ack held low for 3 FETCH cycles -> imem_req=1 and imem_addr constant for 4 cycles; exactly one reg_we pulse per instruction.
REQ-038 Stop and wrap: preload 256 instructions of 8'h5B (XOR), stop=1 asserted during the 256th WB -> pc wraps to 0, retired=256, FSM in IDLE, busy=0.
REQ-039 Reserved opcode 8'hC0: with CPU_SEQ_TRAP_EN -> halted=1, illegal=1, reg_we never 1, pc unchanged, start ignored; without the macro -> reg_we stays 0, pc+1, FSM continues fetching.
REQ-040 Reset mid-operation: rst asserted in the EXEC cycle of an instruction 8'h3F -> no reg_we pulse, pc=0, retired=0, FSM in IDLE one cycle later; start pulsed in the same cycle as rst is ignored.
